// File: rtl/uart_pkg.sv
// Shared definitions for the full-duplex UART.
// - PAR_*          : parity-mode selectors for the PARITY parameter
// - tx_state_e     : transmitter FSM states
// - rx_state_e     : receiver FSM states
// - calc_div       : clock-to-oversample-tick divider
// - parity_bit     : parity bit for a data word under a given mode
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxBreakWait
    } rx_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    // Narrow words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int unsigned mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running counter 0..DIV-1, o_tick high for one
// clock when the counter sits at DIV-1. With DIV=1 the tick is permanently high.
// Ports:
// - i_clk   : system clock
// - i_reset : synchronous active-high reset
// - o_tick  : one-clock oversample enable
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntLast);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/uart_duplex_cfg.sv
// Single-clock full-duplex UART with programmable parity and stop bits,
// 16x-style oversampled receiver with false-start rejection, valid/ready
// transmit handshake and internal loopback.
// Ports:
// - i_clk          : system clock
// - i_reset        : synchronous active-high reset, aborts frames on both sides
// - i_loopback     : 1 = RX listens to the internal TX stream, o_txd held high
// - i_tx_valid     : TX word offered
// - i_tx_data      : TX word, captured on i_tx_valid && o_tx_ready
// - o_tx_ready     : transmitter idle and able to accept
// - o_txd          : serial out, idle high
// - i_rxd          : serial in, asynchronous to i_clk
// - o_rx_data      : last received word
// - o_rx_valid     : one-clock pulse when a frame completes
// - o_parity_error : parity mismatch in the last frame
// - o_stop_error   : first stop bit of the last frame sampled low
// - o_rx_busy      : receiver inside a frame
module uart_duplex_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 1,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_loopback,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_txd,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_error,
    output logic                 o_stop_error,
    output logic                 o_rx_busy
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);

    if (DIV == 0 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || OVERSAMPLE < 8 ||
        (OVERSAMPLE % 2) != 0 || PARITY > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2)
    begin : g_param_check
        $error("uart_duplex_cfg: illegal parameter combination");
    end

    localparam int unsigned     OsW      = $clog2(OVERSAMPLE);
    localparam logic [OsW-1:0]  OsLast   = OsW'(OVERSAMPLE - 1);
    localparam logic [OsW-1:0]  OsHalf   = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

    logic w_tick;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // ------------------------------------------------------------------ TX
    tx_state_e            r_tx_state, w_tx_state_nxt;
    logic [OsW-1:0]       r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_ready;
    logic                 w_tx_accept;
    logic                 w_tx_bit_end;
    logic                 w_tx_serial;

    assign w_tx_accept  = i_tx_valid && r_tx_ready;
    assign w_tx_bit_end = w_tick && (r_tx_cnt == OsLast);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TxIdle;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            TxIdle:   if (w_tx_accept) w_tx_state_nxt = TxStart;
            TxStart:  if (w_tx_bit_end) w_tx_state_nxt = TxData;
            TxData: begin
                if (w_tx_bit_end && (r_tx_bit == DataLast)) begin
                    w_tx_state_nxt = (PARITY != PAR_NONE) ? TxParity : TxStop;
                end
            end
            TxParity: if (w_tx_bit_end) w_tx_state_nxt = TxStop;
            TxStop:   if (w_tx_bit_end && (r_tx_bit == StopLast)) w_tx_state_nxt = TxIdle;
            default:  w_tx_state_nxt = TxIdle;
        endcase
    end

    always_comb begin
        w_tx_serial = 1'b1;
        case (r_tx_state)
            TxStart:  w_tx_serial = 1'b0;
            TxData:   w_tx_serial = r_tx_shift[0];
            TxParity: w_tx_serial = r_tx_par;
            default:  w_tx_serial = 1'b1;
        endcase
    end

    // Bit counter doubles as data index and stop-bit index; it is zero on
    // entry to both DATA and STOP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_ready <= 1'b0;
            r_tx_shift <= i_tx_data;
            r_tx_par   <= parity_bit(MAX_DATA_BITS'(i_tx_data), PARITY);
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else if (r_tx_state == TxIdle) begin
            r_tx_ready <= 1'b1;
        end else if (w_tick) begin
            if (r_tx_cnt == OsLast) begin
                r_tx_cnt <= '0;
                if (r_tx_state == TxData) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= (r_tx_bit == DataLast) ? 4'd0 : r_tx_bit + 4'd1;
                end else if (r_tx_state == TxStop) begin
                    if (r_tx_bit == StopLast) begin
                        r_tx_bit   <= 4'd0;
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_tx_bit <= r_tx_bit + 4'd1;
                    end
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign o_tx_ready = r_tx_ready;
    assign o_txd      = i_loopback ? 1'b1 : w_tx_serial;

    // ------------------------------------------------------------------ RX
    rx_state_e            r_rx_state, w_rx_state_nxt;
    logic [1:0]           r_sync;
    logic [OsW-1:0]       r_rx_cnt;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_error;
    logic                 r_stop_error;
    logic                 w_line;
    logic                 w_rx_sample;
    logic                 w_rx_half;
    logic                 w_rx_busy;

    // Synchroniser idles high so reset does not look like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
        end
    end

    assign w_line      = i_loopback ? w_tx_serial : r_sync[1];
    assign w_rx_sample = w_tick && (r_rx_cnt == OsLast);
    assign w_rx_half   = w_tick && (r_rx_cnt == OsHalf);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_state <= RxIdle;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            RxIdle:  if (w_tick && !w_line) w_rx_state_nxt = RxStart;
            // Start bit must still be low at its centre, otherwise it was a glitch.
            RxStart: if (w_rx_half) w_rx_state_nxt = w_line ? RxIdle : RxData;
            RxData: begin
                if (w_rx_sample && (r_rx_bit == DataLast)) begin
                    w_rx_state_nxt = (PARITY != PAR_NONE) ? RxParity : RxStop;
                end
            end
            RxParity:    if (w_rx_sample) w_rx_state_nxt = RxStop;
            RxStop:      if (w_rx_sample) w_rx_state_nxt = w_line ? RxIdle : RxBreakWait;
            // A low stop bit may be a break; wait for the line to recover.
            RxBreakWait: if (w_tick && w_line) w_rx_state_nxt = RxIdle;
            default:     w_rx_state_nxt = RxIdle;
        endcase
    end

    always_comb begin
        w_rx_busy = 1'b1;
        if (r_rx_state == RxIdle) begin
            w_rx_busy = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rx_par       <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_tick) begin
                case (r_rx_state)
                    RxStart: begin
                        r_rx_cnt <= (r_rx_cnt == OsHalf) ? '0 : r_rx_cnt + 1'b1;
                    end
                    RxData, RxParity, RxStop: begin
                        if (r_rx_cnt == OsLast) begin
                            r_rx_cnt <= '0;
                            case (r_rx_state)
                                RxData: begin
                                    r_rx_shift <= {w_line, r_rx_shift[DATA_BITS-1:1]};
                                    r_rx_bit   <= (r_rx_bit == DataLast) ? 4'd0
                                                                         : r_rx_bit + 4'd1;
                                end
                                RxParity: r_rx_par <= w_line;
                                default: begin
                                    r_rx_data      <= r_rx_shift;
                                    r_rx_valid     <= 1'b1;
                                    r_parity_error <= (PARITY != PAR_NONE) &&
                                        (r_rx_par != parity_bit(MAX_DATA_BITS'(r_rx_shift),
                                                                PARITY));
                                    r_stop_error   <= ~w_line;
                                end
                            endcase
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                    end
                endcase
            end
        end
    end

    assign o_rx_data      = r_rx_data;
    assign o_rx_valid     = r_rx_valid;
    assign o_parity_error = r_parity_error;
    assign o_stop_error   = r_stop_error;
    assign o_rx_busy      = w_rx_busy;

endmodule

// File: tb/tb_uart_duplex_cfg.sv
// Bench for uart_duplex_cfg at DIV=1 (16 clocks per bit), 8 data bits,
// even parity, one stop bit.
module tb_uart_duplex_cfg;

    localparam int unsigned BitClks = 16;
    localparam int unsigned FrameClks = 11 * BitClks;

    logic       clk = 1'b0;
    logic       reset, loopback, tx_valid, tx_ready, txd, rxd;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, parity_error, stop_error, rx_busy;
    logic       rxd_drv, ext_loop;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] rxq[$];  // {stop_error, parity_error, rx_data} per rx_valid pulse

    always #5 clk = ~clk;

    assign rxd = ext_loop ? txd : rxd_drv;

    uart_duplex_cfg #(
        .DATA_BITS  (8),
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16),
        .PARITY     (1),
        .STOP_BITS  (1)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_loopback     (loopback),
        .i_tx_valid     (tx_valid),
        .i_tx_data      (tx_data),
        .o_tx_ready     (tx_ready),
        .o_txd          (txd),
        .i_rxd          (rxd),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .o_parity_error (parity_error),
        .o_stop_error   (stop_error),
        .o_rx_busy      (rx_busy)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxq.push_back({stop_error, parity_error, rx_data});
    end

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic model_parity(input logic [7:0] d);
        return ($countones(d) % 2) != 0;
    endfunction

    // Line levels of one frame in transmission order: start, data LSB first, parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        return {1'b1, model_parity(d), d, 1'b0};
    endfunction

    task automatic drive_rx_frame(input logic [7:0] d, input logic pb, input logic sb);
        logic [10:0] bits;
        bits = {sb, pb, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rxd_drv = bits[i];
            repeat (BitClks - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; loopback = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        rxd_drv = 1'b1; ext_loop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({txd, tx_ready, rx_valid, parity_error, stop_error, rx_busy} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: txd,rdy,vld,perr,serr,busy=%b required 100000",
                     {txd, tx_ready, rx_valid, parity_error, stop_error, rx_busy});
        end
        n_vec++;
        if (rx_data !== 8'h00) begin
            n_err++; $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (tx_ready !== 1'b0) begin
            n_err++; $display("FAIL ready_before_edge: got %b required 0", tx_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (tx_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_rise: got %b required 1", tx_ready);
        end
    endtask

    task automatic test_loopback(input int iters);
        logic [7:0] d;
        int low;
        bit pin_ok, done;
        loopback = 1'b1; ext_loop = 1'b0; rxd_drv = 1'b1;
        for (int it = 0; it < iters; it++) begin
            d = (it == 0) ? 8'hA5 : 8'($urandom);
            rxq.delete();
            @(negedge clk);
            tx_valid = 1'b1; tx_data = d;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            low = 1; pin_ok = (txd === 1'b1); done = 0;
            for (int k = 1; k < 400 && !done; k++) begin
                // An offer while busy must be ignored.
                if (k == 50) begin tx_valid = 1'b1; tx_data = ~d; end
                if (k == 60) tx_valid = 1'b0;
                @(posedge clk);
                #1;
                if (txd !== 1'b1) pin_ok = 0;
                if (tx_ready === 1'b1) done = 1;
                else low++;
            end
            repeat (32) @(posedge clk);
            n_vec++;
            if (!done || low != FrameClks) begin
                n_err++; $display("FAIL lb_ready_low: got %0d clks required %0d", low, FrameClks);
            end
            n_vec++;
            if (!pin_ok) begin
                n_err++; $display("FAIL lb_txd_pin: got toggling required constant 1");
            end
            n_vec++;
            if (rxq.size() != 1) begin
                n_err++; $display("FAIL lb_rx_count: got %0d required 1", rxq.size());
            end else begin
                n_vec++;
                if (rxq[0] !== {2'b00, d}) begin
                    n_err++; $display("FAIL lb_rx_word: got %h required %h", rxq[0], {2'b00, d});
                end
            end
        end
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back(input logic [7:0] d0, input logic [7:0] d1);
        logic stream[$];
        logic exp[$];
        logic [10:0] f;
        int low, gap, low2, first_bad;
        bit second, done;
        loopback = 1'b0; ext_loop = 1'b1;
        rxq.delete();
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d0;
        @(posedge clk);
        #1;
        stream.push_back(txd);
        tx_data = d1;
        low = 1; gap = 0; low2 = 0; second = 0; done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(posedge clk);
            #1;
            stream.push_back(txd);
            if (!second) begin
                if (tx_ready === 1'b1) gap++;
                else if (gap > 0) begin second = 1; tx_valid = 1'b0; low2 = 1; end
                else low++;
            end else begin
                if (tx_ready === 1'b1) done = 1;
                else low2++;
            end
        end
        tx_valid = 1'b0;
        repeat (40) @(posedge clk);
        f = model_frame(d0);
        for (int b = 0; b < 11; b++) for (int s = 0; s < BitClks; s++) exp.push_back(f[b]);
        exp.push_back(1'b1);
        f = model_frame(d1);
        for (int b = 0; b < 11; b++) for (int s = 0; s < BitClks; s++) exp.push_back(f[b]);
        exp.push_back(1'b1);
        n_vec++;
        if (!done || low != FrameClks || low2 != FrameClks) begin
            n_err++;
            $display("FAIL b2b_ready_low: got %0d/%0d clks required %0d/%0d",
                     low, low2, FrameClks, FrameClks);
        end
        n_vec++;
        if (gap != 1) begin
            n_err++; $display("FAIL b2b_ready_gap: got %0d clks required 1", gap);
        end
        first_bad = -1;
        if (stream.size() != exp.size()) first_bad = 0;
        else for (int i = exp.size() - 1; i >= 0; i--) if (stream[i] !== exp[i]) first_bad = i;
        n_vec++;
        if (first_bad >= 0) begin
            n_err++;
            $display("FAIL b2b_txd_wave: got len %0d, first diff at clk %0d; required len %0d",
                     stream.size(), first_bad, exp.size());
        end
        n_vec++;
        if (rxq.size() != 2) begin
            n_err++; $display("FAIL b2b_rx_count: got %0d required 2", rxq.size());
        end else begin
            n_vec++;
            if (rxq[0] !== {2'b00, d0} || rxq[1] !== {2'b00, d1}) begin
                n_err++;
                $display("FAIL b2b_rx_words: got %h %h required %h %h",
                         rxq[0], rxq[1], {2'b00, d0}, {2'b00, d1});
            end
        end
        ext_loop = 1'b0;
    endtask

    task automatic test_parity(input int iters);
        logic [7:0] d;
        logic pb;
        logic [9:0] want;
        loopback = 1'b0; ext_loop = 1'b0; rxd_drv = 1'b1;
        for (int it = -1; it < iters; it++) begin
            if (it < 0) begin d = 8'h01; pb = 1'b0; end
            else begin
                d = 8'($urandom);
                pb = (it == 0) ? model_parity(d) : 1'($urandom);
            end
            want = {1'b0, pb != model_parity(d), d};
            rxq.delete();
            drive_rx_frame(d, pb, 1'b1);
            repeat (40) @(negedge clk);
            n_vec++;
            if (rxq.size() != 1 || rxq[0] !== want) begin
                n_err++;
                $display("FAIL parity_frame: got %0d words first %h required 1 word %h",
                         rxq.size(), (rxq.size() > 0) ? rxq[0] : 10'h0, want);
            end
        end
    endtask

    task automatic test_false_start(input int iters);
        int len, clr;
        bit seen;
        loopback = 1'b0; ext_loop = 1'b0; rxd_drv = 1'b1;
        for (int it = 0; it < iters; it++) begin
            len = $urandom_range(1, 6);
            rxq.delete();
            @(negedge clk);
            rxd_drv = 1'b0;
            repeat (len) @(negedge clk);
            rxd_drv = 1'b1;
            seen = 0; clr = -1;
            for (int k = 0; k < 40 && clr < 0; k++) begin
                @(posedge clk);
                #1;
                if (rx_busy === 1'b1) seen = 1;
                else if (seen) clr = k;
            end
            repeat (300) @(negedge clk);
            n_vec++;
            if (!seen || clr < 0 || clr > 12) begin
                n_err++;
                $display("FAIL false_start_busy: low %0d clks, busy seen %0d cleared at %0d, required <=12",
                         len, seen, clr);
            end
            n_vec++;
            if (rxq.size() != 0) begin
                n_err++; $display("FAIL false_start_valid: got %0d words required 0", rxq.size());
            end
        end
    endtask

    task automatic test_break();
        logic [7:0] d;
        loopback = 1'b0; ext_loop = 1'b0; rxd_drv = 1'b1;
        d = 8'($urandom);
        rxq.delete();
        drive_rx_frame(d, model_parity(d), 1'b0);
        repeat (500) @(negedge clk);
        n_vec++;
        if (rxq.size() != 1 || rxq[0] !== {2'b10, d}) begin
            n_err++;
            $display("FAIL break_frame: got %0d words first %h required 1 word %h",
                     rxq.size(), (rxq.size() > 0) ? rxq[0] : 10'h0, {2'b10, d});
        end
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        n_vec++;
        if (rxq.size() != 1) begin
            n_err++; $display("FAIL break_extra: got %0d words required 1", rxq.size());
        end
        rxq.delete();
        drive_rx_frame(8'h3C, model_parity(8'h3C), 1'b1);
        repeat (40) @(negedge clk);
        n_vec++;
        if (rxq.size() != 1 || rxq[0] !== 10'h03C) begin
            n_err++;
            $display("FAIL break_recover: got %0d words first %h required 1 word 03c",
                     rxq.size(), (rxq.size() > 0) ? rxq[0] : 10'h0);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        loopback = 1'b0; ext_loop = 1'b1;
        d = 8'($urandom);
        rxq.delete();
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (72) @(posedge clk);
        #1;
        n_vec++;
        if (txd !== d[3]) begin
            n_err++; $display("FAIL rst_tx_bit4: got %b required %b", txd, d[3]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({txd, tx_ready, rx_busy, rx_valid, parity_error, stop_error} !== 6'b100000 ||
            rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_state: txd,rdy,busy,vld,perr,serr=%b data=%h required 100000 00",
                     {txd, tx_ready, rx_busy, rx_valid, parity_error, stop_error}, rx_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (tx_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_ready_rise: got %b required 1", tx_ready);
        end
        repeat (300) @(negedge clk);
        n_vec++;
        if (rxq.size() != 0) begin
            n_err++; $display("FAIL rst_no_rx: got %0d words required 0", rxq.size());
        end
        ext_loop = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback(3);
        test_back_to_back(8'h00, 8'hFF);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_parity(5);
        test_false_start(4);
        test_break();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
